// File: rtl/admo_div.sv
// ============================================================================
// Module      : admo_div
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//               Optional macro ADMO_DIV_ZERO_FAST_EN completes a zero-divisor
//               request in one cycle instead of the full iteration sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module admo_div (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             operator_i,
    input  logic [`DATA_WIDTH-1:0] operand_a_i,
    input  logic [`DATA_WIDTH-1:0] operand_b_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [`DATA_WIDTH-1:0] result_o
);

    localparam int DW = `DATA_WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            rem_sel_q, rem_sel_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [DW:0]     rem_q, rem_d;
    logic [DW-1:0]   result_q, result_d;

    // Operand conditioning at acceptance
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_b_zero;
    logic [DW-1:0]   w_a_mag;
    logic [DW-1:0]   w_b_mag;

    assign w_signed = ~operator_i[0];
    assign w_a_neg  = w_signed & operand_a_i[DW-1];
    assign w_b_neg  = w_signed & operand_b_i[DW-1];
    assign w_b_zero = (operand_b_i == '0);
    assign w_a_mag  = w_a_neg ? -operand_a_i : operand_a_i;
    assign w_b_mag  = w_b_neg ? -operand_b_i : operand_b_i;

`ifdef ADMO_DIV_ZERO_FAST_EN
    logic [DW-1:0]   w_dz_result;
    assign w_dz_result = operator_i[1] ? operand_a_i : '1;
`endif

    // One restoring step: dividend bits shift out of dvd_q while quotient bits shift in
    logic [DW:0]     w_shift;
    logic [DW+1:0]   w_diff;
    logic            w_fit;
    logic [DW:0]     w_rem_nxt;
    logic [DW-1:0]   w_quo_nxt;

    assign w_shift   = {rem_q[DW-1:0], dvd_q[DW-1]};
    assign w_diff    = {1'b0, w_shift} - {2'b00, dvs_q};
    assign w_fit     = ~w_diff[DW+1];
    assign w_rem_nxt = w_fit ? w_diff[DW:0] : w_shift;
    assign w_quo_nxt = {dvd_q[DW-2:0], w_fit};

    // Sign fix-up and zero-divisor override on the final step
    logic [DW-1:0]   w_quo_fin;
    logic [DW-1:0]   w_rem_fin;
    logic [DW-1:0]   w_final;
    logic            w_unused_rem;

    assign w_quo_fin    = qneg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fin    = rneg_q ? -w_rem_nxt[DW-1:0] : w_rem_nxt[DW-1:0];
    assign w_final      = dz_q ? (rem_sel_q ? a_q : '1)
                               : (rem_sel_q ? w_rem_fin : w_quo_fin);
    assign w_unused_rem = rem_q[DW] ^ w_rem_nxt[DW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        a_d       = a_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_sel_d = operator_i[1];
                    qneg_d    = w_a_neg ^ w_b_neg;
                    rneg_d    = w_a_neg;
                    dz_d      = w_b_zero;
                    a_d       = operand_a_i;
                    dvd_d     = w_a_mag;
                    dvs_d     = w_b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
`ifdef ADMO_DIV_ZERO_FAST_EN
                    if (w_b_zero) begin
                        state_d  = S_DONE;
                        result_d = w_dz_result;
                    end else begin
                        state_d  = S_CALC;
                    end
`else
                    state_d   = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = w_rem_nxt;
                dvd_d = w_quo_nxt;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = w_final;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            a_q       <= a_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_admo_div.sv
// ============================================================================
// Module      : tb_admo_div
// Description : Directed self-checking bench for admo_div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_admo_div;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  operator_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int n_chk;
    int n_bad;

`ifdef ADMO_DIV_ZERO_FAST_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 32;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    admo_div u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .operator_i  (operator_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, then check latency and result
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        @(negedge clk_i);
        start_i     = 1'b1;
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        operator_i  = ~op;
        operand_a_i = ~a;
        operand_b_i = b ^ 32'h5;
        k = 0;
        while (!valid_o && k < 40) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_res"}, result_o, exp);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check({tag, "_once"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_hold"}, result_o, exp);
    endtask

    initial begin
        int k;
        int n;
        int vcnt;
        logic [31:0] hold_exp [3];

        n_chk       = 0;
        n_bad       = 0;
        rst_i       = 1'b1;
        start_i     = 1'b1;
        operator_i  = OP_DIVU;
        operand_a_i = 32'd10;
        operand_b_i = 32'd2;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy",   {31'd0, busy_o},  32'd0);
        check("rst_valid",  {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o,         32'd0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;

        do_op("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'h0000000E, 32);
        do_op("remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'h00000002, 32);
        do_op("div_m7_2",    OP_DIV,  32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32);
        do_op("rem_m7_2",    OP_REM,  32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFF, 32);
        do_op("div_m100_7",  OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32);
        do_op("rem_m100_7",  OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE, 32);
        do_op("rem_100_m7",  OP_REM,  32'd100,        32'hFFFFFFF9,   32'h00000002, 32);
        do_op("div_ovf",     OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32);
        do_op("rem_ovf",     OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32);
        do_op("divu_max_1",  OP_DIVU, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32);
        do_op("div_dz",      OP_DIV,  32'hFFFFFFFB,   32'h00000000,   32'hFFFFFFFF, ZLAT);
        do_op("remu_dz",     OP_REMU, 32'd5,          32'h00000000,   32'h00000005, ZLAT);
        do_op("rem_dz",      OP_REM,  32'hFFFFFFFB,   32'h00000000,   32'hFFFFFFFB, ZLAT);

        // Abort in the tenth CALC cycle
        @(negedge clk_i);
        start_i     = 1'b1;
        operator_i  = OP_DIVU;
        operand_a_i = 32'h12345678;
        operand_b_i = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("abort_busy",   {31'd0, busy_o},  32'd0);
        check("abort_valid",  {31'd0, valid_o}, 32'd0);
        check("abort_result", result_o,         32'd0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) vcnt++;
        end
        check("abort_novalid", vcnt, 0);
        do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h00000003, 32);

        // start_i held high with operands changing every cycle
        hold_exp[0] = 32'd333;
        hold_exp[1] = 32'd38;
        hold_exp[2] = 32'd26;
        n = 0;
        for (int j = 0; j < 102; j++) begin
            @(negedge clk_i);
            start_i     = 1'b1;
            operator_i  = OP_DIVU;
            operand_a_i = 32'd1000 + 32'(13 * j);
            operand_b_i = 32'd3 + 32'(j);
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                check("hold_idx", j, 34 * n + 32);
                if (n < 3) check("hold_res", result_o, hold_exp[n]);
                n++;
            end
        end
        start_i = 1'b0;
        check("hold_count", n, 3);

        k = 0;
        @(posedge clk_i);
        #1;
        check("final_idle", {31'd0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/admo_div.md
ADMO_DIV -- requirements
Module: admo_div

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed by `DATA_WIDTH (32) from admo_defs.v.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request; SHALL be accepted only when sampled high in IDLE.
REQ-005 operator_i  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 operand_a_i  input  32  dividend, captured at acceptance.
REQ-007 operand_b_i  input  32  divisor, captured at acceptance.
REQ-008 busy_o  output  1  high in CALC and DONE.
REQ-009 valid_o  output  1  single-cycle pulse, high only in DONE.
REQ-010 result_o  output  32  registered result; SHALL hold its value until the next completion or reset.

Function
REQ-011 States: IDLE, CALC, DONE; IDLE->CALC on accepted start_i; CALC->DONE after exactly 32 iterations; DONE->IDLE unconditionally on the next edge.
REQ-012 Operands and operator_i SHALL be registered at acceptance edge E0; later input changes SHALL have no effect on the current operation.
REQ-013 Algorithm: radix-2 restoring division on magnitudes, one quotient bit per CALC cycle, with a 6-bit iteration counter and a 33-bit partial remainder.
REQ-014 Signed ops: magnitudes taken as two's-complement absolute values; quotient negated iff sign(a) XOR sign(b); remainder takes sign(a).
REQ-015 Latency: accepted at E0 -> valid_o high in the cycle following edge E32 -> IDLE at E33; busy_o high from after E0 until E33.
REQ-016 Divide by zero: quotient SHALL be 0xFFFFFFFF (all ops); remainder SHALL equal the original operand_a_i; no sign fix-up applied.
REQ-017 Signed overflow (0x80000000 DIV 0xFFFFFFFF): quotient 0x80000000, remainder 0x00000000.
REQ-018 start_i high in CALC or DONE SHALL be ignored, not queued; a new request is accepted no earlier than the cycle after DONE.
REQ-019 result_o SHALL be written only on the CALC->DONE (or IDLE->DONE) transition.

Reset
REQ-020 rst_i high at an edge SHALL force IDLE, busy_o=0, valid_o=0, result_o=0x00000000, counter=0, from any state.
REQ-021 Reset SHALL dominate a simultaneous start_i; an aborted operation SHALL never produce valid_o.

Configuration
REQ-022 Macro ADMO_DIV_ZERO_FAST_EN: when defined, a zero divisor detected at acceptance SHALL transition IDLE->DONE at E0, loading the REQ-016 result (valid_o high in cycle after E0).
REQ-023 Without ADMO_DIV_ZERO_FAST_EN, a zero divisor SHALL take the full REQ-015 latency with the identical REQ-016 result.

Verification
REQ-024 DIVU 100/7 then REMU 100/7 -> result_o 0x0000000E then 0x00000002, each valid_o exactly once, after E32.
REQ-025 DIV 0xFFFFFFF9/0x00000002 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-026 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; DIVU 0xFFFFFFFF/0x00000001 -> 0xFFFFFFFF.
REQ-027 DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; valid_o after E0 with ADMO_DIV_ZERO_FAST_EN, after E32 without.
REQ-028 rst_i pulsed at the 10th CALC cycle -> busy_o=0, result_o=0 next cycle, no valid_o; following DIVU 9/3 -> 0x00000003.
REQ-029 start_i held high continuously with changing operands -> one accepted op per 34-cycle window, results match operands captured at each acceptance.
